// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud arithmetic used by
// both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-facing bundle: serial line in, received byte and status out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       busy;

    modport master (
        output rx,
        input  data_out,
        input  data_valid,
        input  framing_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data_out,
        output data_valid,
        output framing_err,
        output busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous pin inputs; resets to 1
// so an idle-high line produces no spurious edge after reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic q_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            q_r    <= 1'b1;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit by clock counting and emits a
// one-cycle data_valid or framing_err pulse per frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic             rx_sync_s;
    logic             rx_prev_r;
    state_t           state_r;
    logic [CNT_W-1:0] clk_count_r;
    logic [2:0]       bit_index_r;
    logic [7:0]       shift_r;
    logic [7:0]       data_out_r;
    logic             data_valid_r;
    logic             framing_err_r;
    logic             busy_r;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rx_sync_s)
    );

    // Receive FSM with registered outputs; the counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_prev_r     <= 1'b1;
            state_r       <= IDLE;
            clk_count_r   <= CNT_ZERO;
            bit_index_r   <= 3'd0;
            shift_r       <= 8'h00;
            data_out_r    <= 8'h00;
            data_valid_r  <= 1'b0;
            framing_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            rx_prev_r     <= rx_sync_s;
            data_valid_r  <= 1'b0;
            framing_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    clk_count_r <= CNT_ZERO;
                    bit_index_r <= 3'd0;
                    // Edge-triggered start: a line stuck low never re-arms.
                    if (rx_prev_r && !rx_sync_s) begin
                        state_r <= START_BIT;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                START_BIT: begin
                    if (clk_count_r == HALF_LAST) begin
                        clk_count_r <= CNT_ZERO;
                        if (!rx_sync_s) begin
                            state_r     <= DATA_BITS;
                            bit_index_r <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + CNT_ONE;
                    end
                end
                DATA_BITS: begin
                    if (clk_count_r == BIT_LAST) begin
                        clk_count_r          <= CNT_ZERO;
                        shift_r[bit_index_r] <= rx_sync_s;
                        if (bit_index_r == 3'd7) begin
                            state_r <= STOP_BIT;
                        end else begin
                            bit_index_r <= bit_index_r + 3'd1;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + CNT_ONE;
                    end
                end
                STOP_BIT: begin
                    if (clk_count_r == BIT_LAST) begin
                        clk_count_r <= CNT_ZERO;
                        state_r     <= CLEANUP;
                        if (rx_sync_s) begin
                            data_out_r   <= shift_r;
                            data_valid_r <= 1'b1;
                        end else begin
                            framing_err_r <= 1'b1;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + CNT_ONE;
                    end
                end
                CLEANUP: begin
                    clk_count_r <= CNT_ZERO;
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                end
                default: begin
                    clk_count_r <= CNT_ZERO;
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out    = data_out_r;
    assign bus.data_valid  = data_valid_r;
    assign bus.framing_err = framing_err_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table-driven frames plus
// glitch, back-to-back, mid-frame reset and line-break sequences.
module tb_uart_rx;
    localparam int CF    = 1600;
    localparam int BR    = 100;
    localparam int CPB   = 16;
    localparam int LAT   = 155;   // falling pin to pulse: 2 sync + HALF_BIT + 9*CPB + 1 driven after edge
    localparam int NVEC  = 4;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         n_valid;
        int         n_ferr;
        logic [7:0] exp_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   start;
    int   ev;
    logic busy_prev = 1'b0;

    int valid_cyc[$];
    int valid_dat[$];
    int ferr_cyc[$];
    int busy_fall[$];
    int both_cyc[$];

    vec_t vecs[NVEC];

    uart_rx_if bus ();

    uart_rx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            valid_cyc.push_back(cyc);
            valid_dat.push_back(int'(bus.data_out));
        end
        if (bus.framing_err === 1'b1) ferr_cyc.push_back(cyc);
        if (bus.data_valid === 1'b1 && bus.framing_err === 1'b1) both_cyc.push_back(cyc);
        if (busy_prev === 1'b1 && bus.busy === 1'b0) busy_fall.push_back(cyc);
        busy_prev <= bus.busy;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stop, CPB);
    endtask

    task automatic clear_log();
        valid_cyc.delete();
        valid_dat.delete();
        ferr_cyc.delete();
        busy_fall.delete();
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, n_valid: 1, n_ferr: 0, exp_out: 8'hA5};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, n_valid: 0, n_ferr: 1, exp_out: 8'hA5};
        vecs[2] = '{data: 8'hC3, stop: 1'b1, n_valid: 1, n_ferr: 0, exp_out: 8'hC3};
        vecs[3] = '{data: 8'h7E, stop: 1'b0, n_valid: 0, n_ferr: 1, exp_out: 8'hC3};

        // Reset state
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", int'(bus.data_out), 0);
        check("rst_valid", int'(bus.data_valid), 0);
        check("rst_ferr", int'(bus.framing_err), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        hold(1'b1, 5);

        // Table-driven frames
        for (int i = 0; i < NVEC; i++) begin
            clear_log();
            start = cyc;
            send_frame(vecs[i].data, vecs[i].stop);
            hold(1'b1, 20);
            check("vec_nvalid", valid_cyc.size(), vecs[i].n_valid);
            check("vec_nferr", ferr_cyc.size(), vecs[i].n_ferr);
            check("vec_data_out", int'(bus.data_out), int'(vecs[i].exp_out));
            ev = -1;
            if (valid_cyc.size() > 0) ev = valid_cyc[0];
            else if (ferr_cyc.size() > 0) ev = ferr_cyc[0];
            check("vec_pulse_cycle", ev, start + LAT);
            check("vec_busy_fall", (busy_fall.size() > 0) ? busy_fall[0] : -1, start + LAT + 1);
            check("vec_busy_idle", int'(bus.busy), 0);
        end

        // Three-cycle low glitch
        clear_log();
        hold(1'b0, 3);
        hold(1'b1, 60);
        check("glitch_nvalid", valid_cyc.size(), 0);
        check("glitch_nferr", ferr_cyc.size(), 0);
        check("glitch_busy_fell", busy_fall.size(), 1);
        check("glitch_data_out", int'(bus.data_out), 8'hC3);

        // Back-to-back frames without idle gap
        clear_log();
        start = cyc;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 20);
        check("b2b_nvalid", valid_cyc.size(), 2);
        if (valid_cyc.size() == 2) begin
            check("b2b_first_cycle", valid_cyc[0], start + LAT);
            check("b2b_spacing", valid_cyc[1] - valid_cyc[0], 160);
            check("b2b_first_data", valid_dat[0], 8'h00);
            check("b2b_second_data", valid_dat[1], 8'hFF);
        end
        check("b2b_nferr", ferr_cyc.size(), 0);

        // Reset midway through the data bits of 0x55
        clear_log();
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, 5);
        check("mid_busy_before_reset", int'(bus.busy), 1);
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_data_out", int'(bus.data_out), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_valid", int'(bus.data_valid), 0);
        check("mid_rst_ferr", int'(bus.framing_err), 0);
        rst_n = 1'b1;
        hold(1'b1, 200);
        check("mid_no_valid", valid_cyc.size(), 0);
        check("mid_no_ferr", ferr_cyc.size(), 0);
        clear_log();
        start = cyc;
        send_frame(8'h81, 1'b1);
        hold(1'b1, 20);
        check("post_rst_nvalid", valid_cyc.size(), 1);
        check("post_rst_data", int'(bus.data_out), 8'h81);
        check("post_rst_cycle", (valid_cyc.size() > 0) ? valid_cyc[0] : -1, start + LAT);

        // Line break: 30 bit times low
        clear_log();
        start = cyc;
        hold(1'b0, 30 * CPB);
        check("break_nferr", ferr_cyc.size(), 1);
        check("break_ferr_cycle", (ferr_cyc.size() > 0) ? ferr_cyc[0] : -1, start + LAT);
        check("break_nvalid", valid_cyc.size(), 0);
        check("break_busy_low", int'(bus.busy), 0);
        check("break_busy_falls", busy_fall.size(), 1);
        hold(1'b1, 20);
        check("break_release_nferr", ferr_cyc.size(), 1);
        check("break_release_busy", int'(bus.busy), 0);
        check("break_data_out", int'(bus.data_out), 8'h81);
        clear_log();
        send_frame(8'h96, 1'b1);
        hold(1'b1, 20);
        check("after_break_nvalid", valid_cyc.size(), 1);
        check("after_break_data", int'(bus.data_out), 8'h96);

        check("never_both_pulses", both_cyc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the team's UART transmitter; same baud arithmetic and the same frame format.
- Frame: one start bit (low), eight data bits LSB first, one stop bit (high).
- Synchronises the asynchronous rx pin and samples each bit at its centre by counting system clocks.
- Presents each received byte as a one-cycle valid pulse, or flags a framing error.

Parameters:
- CLOCK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate in bits per second.
- CLKS_PER_BIT, localparam = CLOCK_FREQ / BAUD_RATE (integer division, 5208 at defaults).
- HALF_BIT, localparam = CLKS_PER_BIT / 2 (truncating).
- Elaboration must fail if CLKS_PER_BIT < 4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- rx  in  1  asynchronous serial input; idles high.
- data_out  out  8  last good byte; holds its value until the next good frame.
- data_valid  out  1  one-cycle pulse when data_out updates.
- framing_err  out  1  one-cycle pulse when the stop bit samples low.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: rst_n sampled low on a clk edge sets the following. It aborts any frame in progress; no valid or error pulse is produced for the aborted frame.
  - Outputs: data_out=0, data_valid=0, framing_err=0, busy=0.
  - Internal: state=IDLE, clk_count=0, bit_index=0, shift_reg=0.
  - Synchroniser flops and rx_prev set to 1.
- Input path: two-flop synchroniser produces rx_sync; rx_prev is rx_sync delayed one cycle. The FSM uses only rx_sync and rx_prev.
- clk_count width is $clog2(CLKS_PER_BIT). It always returns to 0 on every state change.
- data_valid and framing_err default to 0 on every cycle; they are never high together.
- IDLE: busy=0. Falling edge (rx_prev=1, rx_sync=0) -> START_BIT with clk_count=0. A line held low does not re-arm; a new falling edge is required.
- START_BIT: count up. When clk_count==HALF_BIT-1, sample rx_sync:
  - 0: go to DATA_BITS with bit_index=0.
  - 1: glitch; go to IDLE with no pulse.
- DATA_BITS: count up. When clk_count==CLKS_PER_BIT-1, write rx_sync into shift_reg[bit_index].
  - bit_index==7: go to STOP_BIT.
  - Otherwise: increment bit_index.
- STOP_BIT: when clk_count==CLKS_PER_BIT-1, sample rx_sync:
  - 1: data_out<=shift_reg and data_valid=1 for the next cycle.
  - 0: framing_err=1 for the next cycle; data_out unchanged.
  - Either case: go to CLEANUP.
- CLEANUP: one cycle, then IDLE. busy is high in START_BIT, DATA_BITS, STOP_BIT and CLEANUP.
- Latency: let E2 be the edge at which IDLE first sees the falling edge; this is two edges after the pin falls.
  - Start-bit check at E2+HALF_BIT.
  - Data bit n (0..7) sampled at E2+HALF_BIT+(n+1)*CLKS_PER_BIT.
  - Stop bit sampled at E2+HALF_BIT+9*CLKS_PER_BIT; the pulse is high in the cycle after that edge.
- Back-to-back frames: a start edge arriving during CLEANUP is caught in IDLE on the next cycle, because rx_prev still reflects the stop level.

Decomposition:
- Package uart_pkg:
  - state_t enum {IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP}, logic [2:0].
  - Function clks_per_bit(freq, baud).
  - Both are shared with the transmitter.
- Sub-module sync_2ff: 1-bit two-flop synchroniser with synchronous active-low reset to value 1. It is reusable for any pin input.

Test Plan:
- Bench parameters: CLOCK_FREQ=1600, BAUD_RATE=100, so CLKS_PER_BIT=16 and HALF_BIT=8.
- Byte 0xA5, good frame -> data_valid high for exactly 1 cycle; data_out=0xA5; busy falls one cycle after the pulse; framing_err stays 0.
- Low glitch of 3 clk cycles on rx -> FSM returns to IDLE; no pulse; data_out keeps its previous value.
- Byte 0x3C sent with stop bit forced low -> framing_err pulses once; data_out still holds 0xA5.
- Two back-to-back frames 0x00 then 0xFF, no idle gap -> two data_valid pulses 160 cycles apart; values 0x00 then 0xFF.
- rst_n low for 1 cycle midway through the data bits of 0x55 -> all outputs reset; no pulse. A following 0x81 frame is received correctly.
- rx held low for 30 bit times (break) -> exactly one framing_err pulse; no further activity until rx goes high then falls again.
